// File: rtl/cpu_subsys_fetch.sv
// Sequential instruction prefetcher between the core fetch stage and a pipelined instruction memory port.
// Optional macro CPU_SUBSYS_FETCH_BYPASS_EN forwards a response straight to the core when the FIFO is empty.
module cpu_subsys_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        mem_valid,
    output logic [29:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned CRW = CW + 1;
    localparam logic [CRW-1:0] DEPTH_C = CRW'(DEPTH);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        STALL = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     fifo_pc_q [DEPTH];
    logic [31:0]     fifo_pc_d [DEPTH];
    logic [31:0]     fifo_data_q [DEPTH];
    logic [31:0]     fifo_data_d [DEPTH];

    logic            push_s;
    logic            pop_s;
    logic            bypass_s;
    logic            fifo_push_s;
    logic            fifo_pop_s;
    logic [CRW-1:0]  credit_s;
    logic            credit_ok_s;

    // A response is kept only if it answers a live request and no redirect is killing it.
    assign push_s      = mem_ready && inflight_q && !drop_q && !redirect_valid;
    assign pop_s       = instr_valid && instr_ready;
    assign fifo_push_s = push_s && !(bypass_s && instr_ready);
    assign fifo_pop_s  = pop_s && (count_q != {CW{1'b0}});
    assign credit_s    = CRW'(count_q) + CRW'(inflight_q) - CRW'(pop_s);
    assign credit_ok_s = credit_s < DEPTH_C;

    assign mem_write = 1'b0;
    assign mem_wdata = 32'h0000_0000;
    assign mem_wstrb = 4'h0;

    // Core-facing stream: FIFO head, or the live response when bypass is built in.
    always_comb begin
        instr_valid = (count_q != {CW{1'b0}}) && !redirect_valid;
        instr_data  = fifo_data_q[rd_ptr_q];
        instr_pc    = fifo_pc_q[rd_ptr_q];
        bypass_s    = 1'b0;
`ifdef CPU_SUBSYS_FETCH_BYPASS_EN
        if ((count_q == {CW{1'b0}}) && push_s) begin
            bypass_s    = 1'b1;
            instr_valid = 1'b1;
            instr_data  = mem_rdata;
            instr_pc    = req_pc_q;
        end else begin
            bypass_s    = 1'b0;
        end
`endif
    end

    // Next-state logic: STALL while every FIFO slot is already claimed.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!credit_ok_s) begin
                        state_d = STALL;
                    end else begin
                        state_d = FETCH;
                    end
                end
                STALL: begin
                    if (pop_s && credit_ok_s) begin
                        state_d = FETCH;
                    end else begin
                        state_d = STALL;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // Request issue; in STALL only a pop this cycle can free a slot.
    always_comb begin
        mem_valid = 1'b0;
        if (rst || redirect_valid) begin
            mem_valid = 1'b0;
        end else begin
            case (state_q)
                FETCH:   mem_valid = credit_ok_s;
                STALL:   mem_valid = pop_s && credit_ok_s;
                default: mem_valid = 1'b0;
            endcase
        end
        mem_addr = mem_valid ? fetch_pc_q[29:0] : 30'h0000_0000;
    end

    // Fetch PC, response tracking and FIFO bookkeeping.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        inflight_d  = mem_valid;
        drop_d      = redirect_valid && inflight_q;
        count_d     = count_q + CW'(fifo_push_s) - CW'(fifo_pop_s);
        wr_ptr_d    = fifo_push_s ? (wr_ptr_q + PW'(1'b1)) : wr_ptr_q;
        rd_ptr_d    = fifo_pop_s ? (rd_ptr_q + PW'(1'b1)) : rd_ptr_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_data_d = fifo_data_q;
        if (fifo_push_s) begin
            fifo_pc_d[wr_ptr_q]   = req_pc_q;
            fifo_data_d[wr_ptr_q] = mem_rdata;
        end else begin
            fifo_pc_d[wr_ptr_q]   = fifo_pc_q[wr_ptr_q];
            fifo_data_d[wr_ptr_q] = fifo_data_q[wr_ptr_q];
        end
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            count_d    = {CW{1'b0}};
            wr_ptr_d   = {PW{1'b0}};
            rd_ptr_d   = {PW{1'b0}};
        end else if (mem_valid) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            req_pc_d   = fetch_pc_q;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 32'h0000_0000;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            count_q    <= {CW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= 32'h0000_0000;
                fifo_data_q[i] <= 32'h0000_0000;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            inflight_q  <= inflight_d;
            drop_q      <= drop_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_data_q <= fifo_data_d;
        end
    end

endmodule

// File: tb/tb_cpu_subsys_fetch.sv
// Scoreboard bench for cpu_subsys_fetch: driver queues expected PCs, monitor checks deliveries and the issue rule.
module tb_cpu_subsys_fetch;
    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
    localparam int DEPTH = 4;
`ifdef CPU_SUBSYS_FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        mem_valid;
    logic [29:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_tail = 32'h0;
    int          outst = 0;
    logic [31:0] iss_pc = 32'h0;
    logic        rst_edge = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_pc = 32'h0;
    logic [31:0] hold_data = 32'h0;
    logic        pend_v = 1'b0;
    logic [29:0] pend_a = 30'h0;

    always #5 clk = ~clk;

    cpu_subsys_fetch #(.RESET_PC(TB_RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a[15:0], a[29:14]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Driver: apply one cycle of stimulus and keep the expected-PC queue topped up.
    task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
        @(posedge clk);
        #1;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        instr_ready    = rdy;
        if (r) begin
            exp_q.delete();
            exp_tail = TB_RESET_PC;
        end else if (rv) begin
            exp_q.delete();
            exp_tail = rp & 32'hFFFF_FFFC;
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_tail);
            exp_tail = exp_tail + 32'd4;
        end
    endtask

    // Memory model: answer every request exactly one cycle later.
    always @(negedge clk) begin
        pend_v = mem_valid;
        pend_a = mem_addr;
    end

    always @(posedge clk) begin
        rst_edge <= rst;
        #1;
        mem_ready = pend_v;
        mem_rdata = pend_v ? mem_word(pend_a) : $urandom;
    end

    // Monitor: reset values, redirect behaviour, issue credit rule, delivered stream, hold stability.
    always @(negedge clk) begin
        logic        p;
        logic [31:0] e;
        chk("tieoff", 32'(mem_write | (|mem_wstrb) | (|mem_wdata)), 32'h0);
        if (hold_prev && !redirect_valid) begin
            chk("hold_valid", 32'(instr_valid), 32'h1);
            chk("hold_pc", instr_pc, hold_pc);
            chk("hold_data", instr_data, hold_data);
        end
        if (rst_edge) begin
            chk("rst_instr_valid", 32'(instr_valid), 32'h0);
            chk("rst_instr_pc", instr_pc, 32'h0);
            chk("rst_instr_data", instr_data, 32'h0);
        end
        if (rst) begin
            chk("rst_mem_valid", 32'(mem_valid), 32'h0);
            chk("rst_mem_addr", 32'(mem_addr), 32'h0);
            outst  = 0;
            iss_pc = TB_RESET_PC;
        end else if (redirect_valid) begin
            chk("redir_instr_valid", 32'(instr_valid), 32'h0);
            chk("redir_mem_valid", 32'(mem_valid), 32'h0);
            outst  = 0;
            iss_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            p = instr_valid && instr_ready;
            chk("issue_rule", 32'(mem_valid), 32'((outst - int'(p)) < DEPTH));
            if (p) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL deliver: got pc %h, expected nothing", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliver_pc", instr_pc, e);
                    chk("deliver_data", instr_data, mem_word(e[29:0]));
                end
            end
            if (mem_valid) begin
                chk("mem_addr", 32'(mem_addr), 32'(iss_pc[29:0]));
                iss_pc = iss_pc + 32'd4;
            end
            outst = outst + int'(mem_valid) - int'(p);
        end
        hold_prev = !rst && !redirect_valid && instr_valid && !instr_ready;
        hold_pc   = instr_pc;
        hold_data = instr_data;
    end

    initial begin
        logic        r;
        logic        rv;
        logic        rdy;
        logic [31:0] rp;

        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);

        // Reset release with core always ready: first word after LAT cycles, then no bubbles.
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            @(negedge clk);
            chk("first_valid", 32'(instr_valid), 32'(c >= LAT));
        end

        // Core stalls: fetching must stop once DEPTH words are claimed.
        repeat (12) step(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("stall_mem_valid", 32'(mem_valid), 32'h0);
        chk("stall_instr_valid", 32'(instr_valid), 32'h1);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset with words buffered and a request in flight.
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("midrst_instr_valid", 32'(instr_valid), 32'h0);
        chk("midrst_instr_pc", instr_pc, 32'h0);

        // Three words buffered plus one in flight, then redirect to 0x100.
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("prebuf_pc", instr_pc, TB_RESET_PC);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        for (int k = 1; k <= LAT + 1; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            @(negedge clk);
            if (k == LAT + 1) begin
                chk("redir_first_valid", 32'(instr_valid), 32'h1);
                chk("redir_first_pc", instr_pc, 32'h0000_0100);
            end else begin
                chk("redir_gap_valid", 32'(instr_valid), 32'h0);
            end
        end
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Misaligned redirect target is rounded down to the word.
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        for (int k = 1; k <= LAT + 1; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("unaligned_redir_pc", instr_pc, 32'h0000_0100);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Randomized traffic: ready jitter, stall bursts, redirects (some near wrap) and resets.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 249) == 0);
            rv  = !r && ($urandom_range(0, 24) == 0);
            rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            if ((i % 400) < 30) rdy = 1'b0;
            step(r, rv, rp, rdy);
        end

        step(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cpu_subsys_fetch.md
# cpu_subsys_fetch

Sequential instruction prefetch unit between the CPU core's fetch stage and instruction port A of the boot ROM / instruction memory. It issues one word-aligned read per cycle on the pipelined memory port, buffers returned words with their PCs in a small FIFO, and hands them to the core over a valid/ready stream. A core redirect (branch/trap) flushes buffered and in-flight words and restarts fetching at the new PC.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `DEPTH`, default `4`: FIFO entries; power of two, 2..16.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `redirect_valid` in 1: core requests restart at `redirect_pc`.
- `redirect_pc` in 32: new fetch PC; bits [1:0] ignored (treated as 0).
- `instr_valid` out 1: `instr_data`/`instr_pc` hold a fetched word.
- `instr_ready` in 1: core accepts the word.
- `instr_data` out 32: instruction word.
- `instr_pc` out 32: byte address of `instr_data`.
- `mem_valid` out 1: read request this cycle.
- `mem_addr` out 30: request address, `pc[29:0]` (byte address, [1:0]=0).
- `mem_write` out 1: tied 0.
- `mem_wdata` out 32: tied 0.
- `mem_wstrb` out 4: tied 0.
- `mem_rdata` in 32: response data.
- `mem_ready` in 1: response valid; arrives exactly one cycle after the `mem_valid` cycle it answers.

## Operation
- Memory port is fully pipelined: every cycle with `mem_valid`=1 is one request; response appears with `mem_ready`=1 the next cycle. No backpressure from memory.
- Registers: `fetch_pc` (32), `inflight` (1 bit, request issued last cycle), `drop` (1 bit), FIFO of `DEPTH` × {pc, data}, count 0..DEPTH.
- FSM: `FETCH` — issue when credit available; `STALL` — credit exhausted (`count + inflight == DEPTH`), `mem_valid`=0; returns to `FETCH` when a pop frees credit. Redirect from either state → `FETCH`.
- Issue rule: `mem_valid = !rst && (count + inflight - pop) < DEPTH`, where `pop = instr_valid && instr_ready`. On issue, `fetch_pc += 4` (wraps 2^32 → 0 silently).
- Response: if `mem_ready` and not `drop`, push {pc of that request, `mem_rdata`}. Response PC tracked by a 32-bit register captured at issue.
- Redirect at cycle N: FIFO count cleared, `fetch_pc <= redirect_pc & ~3`, no request issued at N; `drop <= inflight_at_N` so a response arriving at N+1 is discarded. `instr_valid` forced 0 in cycle N; any pop handshake at N is void (core must not count it). First new request at N+1, first word visible N+3 (N+2 with bypass).
- Redirect and response in the same cycle: response discarded. Redirect while `drop` set: stays dropped correctly (no request issued at N).
- FIFO full cannot overflow: credit counting guarantees a push slot.

## Timing
- Reset values: `instr_valid`=0, `instr_data`=0, `instr_pc`=0, `mem_valid`=0, `mem_addr`=0, FIFO empty, `fetch_pc`=`RESET_PC`, `drop`=0, state `FETCH`.
- First cycle after `rst` deasserts: request to `RESET_PC`; word at `instr_valid` two cycles later (one with bypass).
- Steady state with `instr_ready`=1: one instruction per cycle, no bubbles.
- `instr_*` outputs come from FIFO head register; stable while `instr_valid && !instr_ready` (except on redirect).
- `rst` asserted mid-operation: next edge returns all state to reset values; responses in that window ignored.

## Configuration
- `CPU_SUBSYS_FETCH_BYPASS_EN` defined: when FIFO empty and a non-dropped response arrives, `instr_valid`/`instr_data`/`instr_pc` are driven combinationally from `mem_rdata` in the same cycle; if popped it is not written to the FIFO. Load-to-use 1 cycle.
- Not defined: all responses go through the FIFO; word visible the cycle after `mem_ready`. Outputs register-driven only.

## Test plan
- Reset release, `RESET_PC`=0x0, `instr_ready`=1, memory returns addr-as-data: `instr_pc` 0x0,0x4,0x8,… one per cycle, `instr_data` matches, first valid at cycle 2 (1 with bypass).
- Hold `instr_ready`=0 with `DEPTH`=4: exactly 4 requests issued, `mem_valid` then 0, `instr_pc`=0x0 stable; release ready → fetching resumes, no skipped/duplicated PCs.
- Redirect to 0x100 while 3 words buffered and one in flight: in-flight response dropped, next delivered `instr_pc`=0x100, then 0x104.
- Redirect to 0x103: fetch from 0x100.
- `RESET_PC`=0xFFFF_FFFC: PCs 0xFFFF_FFFC then 0x0000_0000, `mem_addr` wraps.
- Assert `rst` with FIFO full and request in flight: next cycle all outputs at reset values, fetch restarts at `RESET_PC`.
